add_arbiter: RTL and testbench

- Shares a single W-bit adder (z = x + y, W+1-bit result) between N_REQ requesters.
- Round-robin grant, valid/ready handshake on both the request and response sides.
- Registered operands and registered result.
- Sits between the stimulus/requester tasks and the adder datapath. It sequences one add per transaction and tags each result with the requester index.

---
 rtl/add_arbiter.sv | 135 +++++++++++++
 tb/tb_add_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one W-bit adder between N_REQ requesters.
// Optional 16-bit completed-transaction counter (txn_cnt) enabled by ADD_ARB_TXN_CNT_EN.
module add_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*W-1:0]         req_x,
    input  logic [N_REQ*W-1:0]         req_y,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [W:0]                 rsp_z,
    output logic                       busy
`ifdef ADD_ARB_TXN_CNT_EN
    ,
    output logic [15:0]                txn_cnt
`endif
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [W-1:0]    x_r;
    logic [W-1:0]    y_r;
    logic [IDW-1:0]  id_r;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    int unsigned     scan_idx;

    // Scan ptr, ptr+1, ... wrapping mod N_REQ; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = 32'(ptr) + k;
            if (scan_idx >= 32'(N_REQ)) begin
                scan_idx = scan_idx - 32'(N_REQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        ptr_next = (id_r == IDW'(N_REQ - 1)) ? '0 : id_r + 1'b1;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (!rst && grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    state_next          = ADD;
                end
            end
            ADD: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            x_r    <= '0;
            y_r    <= '0;
            id_r   <= '0;
            rsp_z  <= '0;
            rsp_id <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        x_r  <= req_x[32'(grant_id)*W +: W];
                        y_r  <= req_y[32'(grant_id)*W +: W];
                        id_r <= grant_id;
                    end
                end
                ADD: begin
                    rsp_z  <= {1'b0, x_r} + {1'b0, y_r};
                    rsp_id <= id_r;
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr <= ptr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

`ifdef ADD_ARB_TXN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt <= '0;
        end else if (state == RESP && rsp_ready) begin
            txn_cnt <= txn_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a transaction model.
module tb_add_arbiter;

    localparam int N = 4;
    localparam int W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W:0]       rsp_z;
    logic             busy;
`ifdef ADD_ARB_TXN_CNT_EN
    logic [15:0]      txn_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    add_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .busy      (busy)
`ifdef ADD_ARB_TXN_CNT_EN
        ,
        .txn_cnt   (txn_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_op(input int i, input int x, input int y);
        req_x[i*W +: W] = W'(x);
        req_y[i*W +: W] = W'(y);
    endtask

    // Transaction-level model: at most one transaction in flight; its result is
    // visible two cycles after the handshake cycle and retires on rsp_ready.
    bit          m_inflight = 1'b0;
    int          m_ptr = 0;
    int          m_id  = 0;
    int          m_sum = 0;
    int          m_acc = 0;
    int          cyc   = 0;
    int unsigned m_cnt = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit           found;
        bit           exp_valid;
        int           g;
        if (rst) begin
            m_inflight = 1'b0;
            m_ptr      = 0;
            m_cnt      = 0;
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_rsp_z", 32'(rsp_z), 0);
            check("rst_rsp_id", 32'(rsp_id), 0);
        end else begin
            exp_rdy = '0;
            found   = 1'b0;
            g       = 0;
            if (!m_inflight) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        g     = (m_ptr + k) % N;
                    end
                end
                if (found) exp_rdy[g] = 1'b1;
            end
            exp_valid = m_inflight && (cyc >= m_acc + 2);
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(m_inflight));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("rsp_id", 32'(rsp_id), m_id);
                check("rsp_z", 32'(rsp_z), m_sum);
            end
`ifdef ADD_ARB_TXN_CNT_EN
            check("txn_cnt", 32'(txn_cnt), m_cnt % 65536);
`endif
            if (m_inflight) begin
                if (exp_valid && rsp_ready) begin
                    m_inflight = 1'b0;
                    m_ptr      = (m_id + 1) % N;
                    m_cnt++;
                end
            end else if (found) begin
                m_inflight = 1'b1;
                m_acc      = cyc;
                m_id       = g;
                m_sum      = int'(req_x[g*W +: W]) + int'(req_y[g*W +: W]);
            end
        end
        cyc++;
    end

    // One isolated transaction from an idle DUT with rsp_ready=1; called at posedge+2.
    task automatic single(input int id, input int x, input int y, input int ez);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        set_op(id, x, y);
        #1 check("single_grant", 32'(req_ready), 32'(1) << id);
        @(posedge clk); #2;
        req_valid = '0;
        check("single_add_busy", 32'(busy), 1);
        check("single_add_novalid", 32'(rsp_valid), 0);
        @(posedge clk); #2;
        check("single_valid", 32'(rsp_valid), 1);
        check("single_id", 32'(rsp_id), id);
        check("single_z", 32'(rsp_z), ez);
        @(posedge clk); #2;
        check("single_idle", 32'(busy), 0);
    endtask

    int exp_g[5] = '{0, 1, 2, 3, 0};
    int exp_z[5] = '{2, 4, 6, 8, 2};

    initial begin
        logic [N-1:0] seen;
        rst       = 1'b1;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        check("reset_ready_masked", 32'(req_ready), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(rsp_valid), 0);
        req_valid = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        single(0, 5, 5, 10);
        single(2, 7, 7, 14);
        single(2, 0, 0, 0);

        // Fairness from a freshly reset pointer.
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, i + 1, i + 1);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_grant", 32'(req_ready), 32'(1) << exp_g[k]);
            @(posedge clk); #2;
            @(posedge clk); #2;
            check("rr_z", 32'(rsp_z), exp_z[k]);
            check("rr_id", 32'(rsp_id), exp_g[k]);
            @(posedge clk); #2;
        end
`ifdef ADD_ARB_TXN_CNT_EN
        check("txn_cnt_after_5", 32'(txn_cnt), 5);
`endif

        // Backpressure: requester 1 stalls, requester 3 waits.
        req_valid = 4'b0010;
        set_op(1, 6, 3);
        rsp_ready = 1'b0;
        #1 check("bp_grant1", 32'(req_ready), 32'h2);
        @(posedge clk); #2;
        req_valid = 4'b1000;
        set_op(3, 2, 4);
        check("bp_add_noready", 32'(req_ready), 0);
        @(posedge clk); #2;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 32'(rsp_valid), 1);
            check("bp_hold_z", 32'(rsp_z), 9);
            check("bp_hold_id", 32'(rsp_id), 1);
            check("bp_hold_noready", 32'(req_ready), 0);
            @(posedge clk); #2;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_grant3", 32'(req_ready), 32'h8);
        @(posedge clk); #2;
        req_valid = '0;
        @(posedge clk); #2;
        check("bp_z3", 32'(rsp_z), 6);
        @(posedge clk); #2;

        // Asynchronous reset while in ADD.
        req_valid = 4'b0001;
        set_op(0, 1, 1);
        #1 check("ar_grant0", 32'(req_ready), 32'h1);
        @(posedge clk); #2;
        req_valid = '0;
        check("ar_in_add", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("ar_valid_now", 32'(rsp_valid), 0);
        check("ar_busy_now", 32'(busy), 0);
        check("ar_z_now", 32'(rsp_z), 0);
        @(negedge clk);
        @(posedge clk); #2;
        rst       = 1'b0;
        req_valid = 4'b0011;
        set_op(0, 2, 3);
        set_op(1, 4, 4);
        #1 check("ar_ptr0_wins", 32'(req_ready), 32'h1);
        @(posedge clk); #2;
        req_valid = 4'b0010;
        @(posedge clk); #2;
        check("ar_z0", 32'(rsp_z), 5);
        @(posedge clk); #2;
        check("ar_then1", 32'(req_ready), 32'h2);
        @(posedge clk); #2;
        req_valid = '0;
        @(posedge clk); #2;
        check("ar_z1", 32'(rsp_z), 8);
        @(posedge clk); #2;

        // Randomized traffic: requesters hold until granted, may withdraw early.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            seen = req_valid & req_ready;
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (seen[i]) begin
                    req_valid[i] = $urandom_range(1, 0) == 1;
                    set_op(i, $urandom_range(7, 0), $urandom_range(7, 0));
                end else if (req_valid[i]) begin
                    if ($urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    req_valid[i] = 1'b1;
                    set_op(i, $urandom_range(7, 0), $urandom_range(7, 0));
                end
            end
            rsp_ready = $urandom_range(3, 0) != 0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
